uart_cfg_arbiter: RTL and testbench

- Sequences and shares the UART register-file write port (valid/address/data/ack) between two configuration requesters.
- After reset, it first runs a built-in boot sequence that writes default frame settings into the regfile. It then round-robin arbitrates requester 0 and requester 1, one write transaction at a time.
- Sits between the system-side config sources and the UART module's regfile port, in the `clk` domain.

---
 rtl/uart_cfg_arbiter_if.sv | 29 ++
 rtl/uart_cfg_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_cfg_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_arbiter_if.sv
// Regfile write port plus the two configuration-requester handshakes.
// The arbiter connects through the master modport; the config sources and regfile use the slave modport.
interface uart_cfg_arbiter_if;
  logic       req0;
  logic [3:0] addr0;
  logic [3:0] data0;
  logic       done0;
  logic       req1;
  logic [3:0] addr1;
  logic [3:0] data1;
  logic       done1;
  logic       rf_valid;
  logic [3:0] rf_address;
  logic [3:0] rf_data;
  logic       rf_ack;
  logic       boot_done;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  req0, addr0, data0, req1, addr1, data1, rf_ack,
    output done0, done1, rf_valid, rf_address, rf_data, boot_done, busy, timeout_err
  );

  modport slave (
    output req0, addr0, data0, req1, addr1, data1, rf_ack,
    input  done0, done1, rf_valid, rf_address, rf_data, boot_done, busy, timeout_err
  );
endinterface

// File: rtl/uart_cfg_arbiter.sv
// Boot-sequences default UART frame settings, then round-robin shares the regfile write port.
// Optional ack timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_cfg_arbiter #(
  parameter logic       DEF_PARITY      = 1'b0,
  parameter logic       DEF_PARITY_TYPE = 1'b0,
  parameter logic       DEF_STOP_BITS   = 1'b0,
  parameter logic [3:0] DEF_FRAME_LEN   = 4'd8,
  parameter int         TIMEOUT         = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_cfg_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_BOOT, S_BOOT_WAIT, S_IDLE, S_XFER} state_t;

  state_t     r_state, w_next;
  logic [1:0] r_idx, w_idx;
  logic       r_ptr, w_ptr;
  logic       r_rf_valid, w_rf_valid;
  logic [3:0] r_rf_address, w_rf_address;
  logic [3:0] r_rf_data, w_rf_data;
  logic       r_done0, w_done0;
  logic       r_done1, w_done1;
  logic       r_boot_done, w_boot_done;
  logic       r_busy, w_busy;
  logic       r_timeout_err, w_timeout_err;
  logic       w_ack, w_req, w_grant1, w_tmo;

  function automatic logic [3:0] boot_val(input logic [1:0] idx);
    case (idx)
      2'd0:    boot_val = {3'b000, DEF_PARITY};
      2'd1:    boot_val = {3'b000, DEF_PARITY_TYPE};
      2'd2:    boot_val = {3'b000, DEF_STOP_BITS};
      default: boot_val = DEF_FRAME_LEN;
    endcase
  endfunction

  assign w_ack    = bus.rf_ack & r_rf_valid;
  assign w_req    = bus.req0 | bus.req1;
  // On a tie the requester that did not win last time is served.
  assign w_grant1 = bus.req1 & (~bus.req0 | ~r_ptr);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        w_wait;

  assign w_wait = (r_state == S_BOOT_WAIT) || (r_state == S_XFER);
  assign w_tmo  = w_wait && !w_ack && (r_cnt == 16'(TIMEOUT - 1));

  // Both wait states are only entered from BOOT or IDLE, where the count is held at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_cnt <= '0;
    else if (!w_wait) r_cnt <= '0;
    else             r_cnt <= r_cnt + 16'd1;
  end
`else
  logic w_unused_timeout;
  assign w_tmo            = 1'b0;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_BOOT;
      r_idx         <= 2'd0;
      r_ptr         <= 1'b1;
      r_rf_valid    <= 1'b0;
      r_rf_address  <= 4'd0;
      r_rf_data     <= 4'd0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_boot_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_idx         <= w_idx;
      r_ptr         <= w_ptr;
      r_rf_valid    <= w_rf_valid;
      r_rf_address  <= w_rf_address;
      r_rf_data     <= w_rf_data;
      r_done0       <= w_done0;
      r_done1       <= w_done1;
      r_boot_done   <= w_boot_done;
      r_busy        <= w_busy;
      r_timeout_err <= w_timeout_err;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_BOOT:      w_next = S_BOOT_WAIT;
      S_BOOT_WAIT: begin
        if (w_ack)      w_next = (r_idx == 2'd3) ? S_IDLE : S_BOOT;
        else if (w_tmo) w_next = S_BOOT;
      end
      S_IDLE:      if (w_req) w_next = S_XFER;
      S_XFER:      if (w_ack || w_tmo) w_next = S_IDLE;
      default:     w_next = S_BOOT;
    endcase
  end

  always_comb begin
    w_idx         = r_idx;
    w_ptr         = r_ptr;
    w_rf_valid    = r_rf_valid;
    w_rf_address  = r_rf_address;
    w_rf_data     = r_rf_data;
    w_done0       = 1'b0;
    w_done1       = 1'b0;
    w_boot_done   = r_boot_done;
    w_timeout_err = 1'b0;
    w_busy        = (w_next != S_IDLE);
    unique case (r_state)
      S_BOOT: begin
        w_rf_valid   = 1'b1;
        w_rf_address = {2'b00, r_idx};
        w_rf_data    = boot_val(r_idx);
      end
      S_BOOT_WAIT: begin
        if (w_ack) begin
          w_rf_valid = 1'b0;
          w_idx      = r_idx + 2'd1;
          if (r_idx == 2'd3) w_boot_done = 1'b1;
        end else if (w_tmo) begin
          w_rf_valid    = 1'b0;
          w_timeout_err = 1'b1;
        end
      end
      S_IDLE: begin
        w_rf_valid = 1'b0;
        if (w_req) begin
          w_rf_valid   = 1'b1;
          w_ptr        = w_grant1;
          w_rf_address = w_grant1 ? bus.addr1 : bus.addr0;
          w_rf_data    = w_grant1 ? bus.data1 : bus.data0;
        end
      end
      S_XFER: begin
        // The grant pointer doubles as the owner of the outstanding transfer.
        if (w_ack || w_tmo) begin
          w_rf_valid    = 1'b0;
          w_done0       = ~r_ptr;
          w_done1       = r_ptr;
          w_timeout_err = w_tmo;
        end
      end
      default: w_rf_valid = 1'b0;
    endcase
  end

  assign bus.rf_valid    = r_rf_valid;
  assign bus.rf_address  = r_rf_address;
  assign bus.rf_data     = r_rf_data;
  assign bus.done0       = r_done0;
  assign bus.done1       = r_done1;
  assign bus.boot_done   = r_boot_done;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_cfg_arbiter.sv
// Directed plus randomized bench for uart_cfg_arbiter; the bench plays both requesters and the regfile.
module tb_uart_cfg_arbiter;
  localparam logic       DEF_P  = 1'b0;
  localparam logic       DEF_PT = 1'b0;
  localparam logic       DEF_SB = 1'b0;
  localparam logic [3:0] DEF_FL = 4'd8;
  localparam int         TMO    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cfg_arbiter_if bus ();

  uart_cfg_arbiter #(
    .DEF_PARITY(DEF_P), .DEF_PARITY_TYPE(DEF_PT), .DEF_STOP_BITS(DEF_SB),
    .DEF_FRAME_LEN(DEF_FL), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         last_g;
  int         g;
  int         lat;
  int         n;
  logic [3:0] boot_exp [4];
  logic       p0, p1;
  logic [3:0] a0, d0, a1, d1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.rf_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("valid_seen", 16'(bus.rf_valid), 16'd1);
  endtask

  task automatic ack_after(input int delay, input logic [3:0] ea, input logic [3:0] ed);
    repeat (delay) @(negedge clk);
    chk("hold_valid", 16'(bus.rf_valid), 16'd1);
    chk("hold_addr", 16'(bus.rf_address), 16'(ea));
    chk("hold_data", 16'(bus.rf_data), 16'(ed));
    bus.rf_ack = 1'b1;
    @(negedge clk);
    bus.rf_ack = 1'b0;
    chk("valid_drop", 16'(bus.rf_valid), 16'd0);
  endtask

  task automatic expect_grant(input int gi, input int delay, input logic [3:0] ea,
                              input logic [3:0] ed, input bit perturb);
    int cyc;
    wait_valid(cyc);
    chk("grant_lat", 16'(cyc), 16'd1);
    chk("grant_addr", 16'(bus.rf_address), 16'(ea));
    chk("grant_data", 16'(bus.rf_data), 16'(ed));
    chk("grant_busy", 16'(bus.busy), 16'd1);
    if (perturb) begin
      if (gi == 1) begin bus.addr1 = ~ea; bus.data1 = ~ed; end
      else         begin bus.addr0 = ~ea; bus.data0 = ~ed; end
    end
    ack_after(delay, ea, ed);
    chk("done0", 16'(bus.done0), 16'(gi == 0));
    chk("done1", 16'(bus.done1), 16'(gi == 1));
    chk("idle_busy", 16'(bus.busy), 16'd0);
    last_g = gi;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    boot_exp[0] = {3'b000, DEF_P};
    boot_exp[1] = {3'b000, DEF_PT};
    boot_exp[2] = {3'b000, DEF_SB};
    boot_exp[3] = DEF_FL;
    rst = 1'b0;
    bus.req0 = 1'b0; bus.addr0 = 4'd0; bus.data0 = 4'd0;
    bus.req1 = 1'b0; bus.addr1 = 4'd0; bus.data1 = 4'd0;
    bus.rf_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 16'(bus.rf_valid), 16'd0);
    chk("rst_addr", 16'(bus.rf_address), 16'd0);
    chk("rst_data", 16'(bus.rf_data), 16'd0);
    chk("rst_boot_done", 16'(bus.boot_done), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'({bus.done0, bus.done1, bus.timeout_err}), 16'd0);

    // Requester 1 waits through the whole boot sequence.
    a1 = 4'($urandom); d1 = 4'($urandom);
    bus.addr1 = a1; bus.data1 = d1; bus.req1 = 1'b1;
    last_g = 1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(lat);
      chk("boot_lat", 16'(lat), 16'd1);
      chk("boot_addr", 16'(bus.rf_address), 16'(i));
      chk("boot_data", 16'(bus.rf_data), 16'(boot_exp[i]));
      chk("boot_not_done", 16'(bus.boot_done), 16'd0);
      ack_after(2, 4'(i), boot_exp[i]);
      chk("boot_no_done1", 16'(bus.done1), 16'd0);
    end
    chk("boot_done", 16'(bus.boot_done), 16'd1);
    chk("boot_busy_fall", 16'(bus.busy), 16'd0);

    expect_grant(1, 1, a1, d1, 1'b1);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("done1_single", 16'(bus.done1), 16'd0);

    bus.addr0 = 4'h2; bus.data0 = 4'h1; bus.req0 = 1'b1;
    expect_grant(0, 2, 4'h2, 4'h1, 1'b0);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("done0_single", 16'(bus.done0), 16'd0);

    // Both requesters held continuously: strict alternation with a dead cycle each time.
    bus.addr0 = 4'h3; bus.data0 = 4'hC; bus.addr1 = 4'hA; bus.data1 = 4'h5;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = 1 - last_g;
      expect_grant(g, 0, (g == 1) ? 4'hA : 4'h3, (g == 1) ? 4'h5 : 4'hC, 1'b0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    for (int r = 0; r < 24; r++) begin
      p0 = 1'($urandom_range(0, 1));
      p1 = 1'($urandom_range(0, 1));
      if (!p0 && !p1) p0 = 1'b1;
      a0 = 4'($urandom); d0 = 4'($urandom); a1 = 4'($urandom); d1 = 4'($urandom);
      bus.addr0 = a0; bus.data0 = d0; bus.addr1 = a1; bus.data1 = d1;
      bus.req0 = p0; bus.req1 = p1;
      while (p0 || p1) begin
        g = (p0 && p1) ? 1 - last_g : (p1 ? 1 : 0);
        expect_grant(g, $urandom_range(0, 3), (g == 1) ? a1 : a0, (g == 1) ? d1 : d0, 1'b1);
        if (g == 1) begin bus.req1 = 1'b0; p1 = 1'b0; end
        else        begin bus.req0 = 1'b0; p0 = 1'b0; end
      end
    end

    // A stray ack with nothing outstanding has no effect.
    bus.rf_ack = 1'b1;
    @(negedge clk);
    bus.rf_ack = 1'b0;
    chk("stray_ack_valid", 16'(bus.rf_valid), 16'd0);
    chk("stray_ack_done", 16'({bus.done0, bus.done1}), 16'd0);
    chk("stray_ack_busy", 16'(bus.busy), 16'd0);

    bus.addr0 = 4'h6; bus.data0 = 4'h9; bus.req0 = 1'b1;
    wait_valid(lat);
    chk("tmo_grant_lat", 16'(lat), 16'd1);
    chk("tmo_grant_addr", 16'(bus.rf_address), 16'h6);
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (bus.rf_valid === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 16'(n), 16'(TMO));
    chk("tmo_err", 16'(bus.timeout_err), 16'd1);
    chk("tmo_done0", 16'(bus.done0), 16'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("tmo_err_pulse", 16'(bus.timeout_err), 16'd0);
`else
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.rf_valid !== 1'b1 || bus.timeout_err !== 1'b0) n++;
    end
    chk("no_tmo_hold", 16'(n), 16'd0);
`endif

    // Reset in the middle of a transfer.
    bus.req0 = 1'b1;
    wait_valid(lat);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 16'(bus.rf_valid), 16'd0);
    chk("arst_busy", 16'(bus.busy), 16'd0);
    chk("arst_done0", 16'(bus.done0), 16'd0);
    chk("arst_boot_done", 16'(bus.boot_done), 16'd0);
    bus.req0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_done0", 16'(bus.done0), 16'd0);
    end
    rst = 1'b1;
    wait_valid(lat);
    chk("reboot_lat", 16'(lat), 16'd1);
    chk("reboot_addr", 16'(bus.rf_address), 16'd0);
    chk("reboot_data", 16'(bus.rf_data), 16'(boot_exp[0]));
    chk("reboot_no_done0", 16'(bus.done0), 16'd0);
    ack_after(1, 4'd0, boot_exp[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
